// File: rtl/riscv_pkg.sv
// Shared RV32 load/store encodings, LSU state type and access-rule helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_DONE
  } lsu_state_e;

  // Unsigned widths exist only for loads; stores accept B/H/W only.
  function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    access_ok = 1'b1;
      F3_H:    access_ok = ~addr_lo[0];
      F3_W:    access_ok = (addr_lo == 2'b00);
      F3_BU:   access_ok = ~we;
      F3_HU:   access_ok = ~we & ~addr_lo[0];
      default: access_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    store_strb = 4'b0001 << addr_lo;
      F3_H:    store_strb = 4'b0011 << addr_lo;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] funct3,
                                                 input logic [XLEN-1:0] wdata);
    case (funct3)
      F3_B:    store_data = {4{wdata[7:0]}};
      F3_H:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned memory bus between the LSU (master) and memory (slave).
interface load_store_unit_if;
  import riscv_pkg::*;

  logic            mem_valid;
  logic            mem_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/half of a bus word and sign- or zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] readdata_o
);

  logic [XLEN-1:0] lane;

  always_comb begin
    lane = mem_rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      F3_B:    readdata_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    readdata_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   readdata_o = {24'h0, lane[7:0]};
      F3_HU:   readdata_o = {16'h0, lane[15:0]};
      default: readdata_o = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one bus transaction per memory instruction, stalling the
// pipeline until the access completes, faults, or times out.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                stall,
  output logic [XLEN-1:0]     readdata,
  output logic                fault,
  output logic                bus_err,
  load_store_unit_if.master   mem
);

  lsu_state_e      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      strb_q, strb_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            legal;
  logic [8:0]      cnt_inc;
  logic            timeout_hit;
  logic [XLEN-1:0] ext_data;

  load_extend u_load_extend (
    .mem_rdata_i (rdata_q),
    .addr_lo_i   (addr_q[1:0]),
    .funct3_i    (funct3_q),
    .readdata_o  (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LSU_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      strb_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      strb_q   <= strb_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    legal       = access_ok(req_we, req_funct3, req_addr[1:0]);
    cnt_inc     = {1'b0, cnt_q} + 9'd1;
    timeout_hit = (cnt_inc == 9'(TIMEOUT));

    case (state_q)
      LSU_IDLE: begin
        if (req_valid && legal) begin
          state_d  = LSU_REQ;
          cnt_d    = '0;
          err_d    = 1'b0;
          we_d     = req_we;
          addr_d   = req_addr;
          funct3_d = req_funct3;
          strb_d   = req_we ? store_strb(req_funct3, req_addr[1:0]) : 4'b0000;
          wdata_d  = store_data(req_funct3, req_wdata);
        end
      end
      LSU_REQ: begin
        // A response arriving on the timeout cycle still counts as success.
        if (mem.mem_ready) begin
          state_d = LSU_DONE;
          rdata_d = mem.mem_rdata;
        end else begin
          cnt_d = cnt_inc[7:0];
          if (timeout_hit) begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
          end
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    fault         = req_valid & (state_q == LSU_IDLE) & ~legal & ~rst;
    stall         = req_valid & (state_q != LSU_DONE) & ~fault;
    bus_err       = (state_q == LSU_DONE) & err_q;
    readdata      = ((state_q == LSU_DONE) && !we_q && !err_q) ? ext_data : '0;
    mem.mem_valid = (state_q == LSU_REQ);
    mem.mem_we    = we_q;
    mem.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    mem.mem_wstrb = strb_q;
    mem.mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes modelled outcomes, a
// monitor pops and compares as each instruction retires; a slave answers the bus.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] readdata;
  logic        fault;
  logic        bus_err;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .readdata   (readdata),
    .fault      (fault),
    .bus_err    (bus_err),
    .mem        (bus)
  );

  typedef struct {
    logic        fault;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned mv;
    int unsigned stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int unsigned slv_delay = 0;
  logic [31:0] slv_rdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference outcome from the architectural load/store rules.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int unsigned dly);
    exp_t        e;
    int unsigned size;
    int unsigned off;
    logic        legal_f3;
    logic [31:0] v;
    size     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off      = int'(addr[1:0]);
    legal_f3 = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    e.fault  = !legal_f3 || (addr % size) != 0;
    e.we     = we;
    e.addr   = addr & 32'hFFFF_FFFC;
    e.strb   = we ? 4'(((1 << size) - 1) << off) : 4'b0000;
    e.wdata  = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
               (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    e.err    = !e.fault && dly >= TO;
    e.mv     = e.fault ? 0 : (dly < TO ? dly + 1 : TO);
    e.stalls = e.fault ? 0 : 1 + e.mv;
    v = rdata >> (8 * off);
    if (size == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    e.rdata = (e.fault || we || e.err) ? 32'h0 : v;
    return e;
  endfunction

  // Memory slave: answers after slv_delay REQ cycles, drives noise otherwise.
  initial begin : slave
    int unsigned k;
    k = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_valid) begin
        bus.mem_ready = (k == slv_delay);
        bus.mem_rdata = (k == slv_delay) ? slv_rdata : $urandom();
        k++;
      end else begin
        k = 0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom();
      end
    end
  end

  initial begin : monitor
    int unsigned mv;
    int unsigned st;
    exp_t        cur;
    mv = 0;
    st = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mv = 0;
        st = 0;
        continue;
      end
      if (!req_valid) begin
        check("idle_mem_valid", 32'(bus.mem_valid), 32'h0);
        check("idle_readdata", readdata, 32'h0);
        mv = 0;
        st = 0;
        continue;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got activity expected none (t=%0t)", $time);
        continue;
      end
      cur = exp_q[0];
      if (bus.mem_valid) begin
        mv++;
        check("mem_addr", bus.mem_addr, cur.addr);
        check("mem_we", 32'(bus.mem_we), 32'(cur.we));
        check("mem_wstrb", 32'(bus.mem_wstrb), 32'(cur.strb));
        if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
      end
      if (stall) begin
        st++;
        check("busy_readdata", readdata, 32'h0);
        check("busy_bus_err", 32'(bus_err), 32'h0);
      end else begin
        void'(exp_q.pop_front());
        check("fault", 32'(fault), 32'(cur.fault));
        check("readdata", readdata, cur.rdata);
        check("bus_err", 32'(bus_err), 32'(cur.err));
        check("mem_valid_cycles", 32'(mv), 32'(cur.mv));
        check("stall_cycles", 32'(st), 32'(cur.stalls));
        mv = 0;
        st = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int unsigned dly);
    bit done;
    exp_q.push_back(model(we, f3, addr, wdata, rdata, dly));
    slv_delay  = dly;
    slv_rdata  = rdata;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout: stall still %b after 40 cycles, expected release", stall);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom();
    req_funct3 = 3'($urandom_range(0, 7));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

  logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

  initial begin : stim
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    #1;
    check("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 2);
    issue(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 0);
    issue(1'b0, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 0);
    issue(1'b0, 3'b010, 32'h300, 32'h0, 32'h1234_5678, 50);
    issue(1'b0, 3'b001, 32'h302, 32'h0, 32'h8001_7FFF, TO - 1);
    issue(1'b1, 3'b100, 32'h400, 32'h55, 32'h0, 0);
    issue(1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 0);

    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)], $urandom(),
            $urandom(), $urandom(), $urandom_range(0, TO + 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // Abort a store mid-transaction with an asynchronous reset.
    mon_en     = 1'b0;
    slv_delay  = 100;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h0000_0551;
    req_wdata  = 32'h0000_00A5;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mem_valid", 32'(bus.mem_valid), 32'h1);
    #2;
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    check("async_mem_valid", 32'(bus.mem_valid), 32'h0);
    check("async_mem_we", 32'(bus.mem_we), 32'h0);
    check("async_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    check("async_mem_addr", bus.mem_addr, 32'h0);
    check("async_mem_wdata", bus.mem_wdata, 32'h0);
    check("async_readdata", readdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_req", 32'(bus.mem_valid), 32'h0);
      check("post_rst_stall", 32'(stall), 32'h0);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    issue(1'b0, 3'b101, 32'h0000_0602, 32'h0, 32'hFEDC_BA98, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
